dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the byte-addressed data memory. It shares the single `datamem` access port between the core load/store unit (port 0) and a secondary master such as a debug or DMA engine (port 1). Each request is checked for size encoding, alignment and range, then presented to memory for exactly one cycle. The block absorbs the memory's one-cycle registered read latency and returns a response to the originating port.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_req_check.sv | 26 ++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// Optional feature macro used by dmem_arbiter: DMEM_ARB_ROUND_ROBIN_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    RW_BYTE = 2'b00,
    RW_HALF = 2'b01,
    RW_WORD = 2'b10
  } rw_type;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_t;

  // rtype is kept as raw bits so the illegal encoding 2'b11 survives capture.
  typedef struct packed {
    logic        we;
    logic [1:0]  rtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sign_ext;
  } dmem_req_t;

  localparam logic [1:0] TYPE_WORD_IDLE = 2'b10;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] access_bytes(input logic [1:0] t);
    case (t)
      RW_BYTE: access_bytes = 3'd1;
      RW_HALF: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of one memory request: size encoding,
// natural alignment and range against ADDR_LIMIT (33-bit, no wrap).
// Used by dmem_arbiter (macro DMEM_ARB_ROUND_ROBIN_EN does not affect it).
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h20000
) (
  input  logic [1:0]  rtype_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  logic [32:0] end_addr;

  // Flag any illegal size, misalignment or out-of-range access.
  always_comb begin
    end_addr = {1'b0, addr_i} + {30'd0, access_bytes(rtype_i)};
    err_o    = 1'b0;
    if (rtype_i == 2'b11)                                err_o = 1'b1;
    if (rtype_i == RW_HALF && addr_i[0])                 err_o = 1'b1;
    if (rtype_i == RW_WORD && addr_i[1:0] != 2'b00)      err_o = 1'b1;
    if (end_addr > {1'b0, ADDR_LIMIT})                   err_o = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single datamem port.
// One request in flight: IDLE -> ACCESS -> RESP, or IDLE -> RESP on error.
// Macro DMEM_ARB_ROUND_ROBIN_EN: alternate grants when both ports are
// valid; otherwise port 0 has fixed priority and no pointer exists.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_we,
  input  logic [1:0]  p0_type,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_sign_ext,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_we,
  input  logic [1:0]  p1_type,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_sign_ext,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic        mem_write_en,
  output logic [1:0]  mem_type_control,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_dout
);

  arb_state_t state_q, state_d;
  dmem_req_t  req_q, req_d, win_req;
  logic       port_q, port_d;
  logic       err_q, err_d;
  logic       any_valid, win_port, chk_err, accept;
  logic [31:0] rdata_sel;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;   // port favoured when both are valid
`endif

  // Pick the winning port and mux its request fields.
  always_comb begin
    any_valid = p0_req_valid | p1_req_valid;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    win_port  = (p0_req_valid && p1_req_valid) ? rr_q : !p0_req_valid;
`else
    win_port  = !p0_req_valid;
`endif
    if (win_port) win_req = '{we: p1_we, rtype: p1_type, addr: p1_addr,
                              wdata: p1_wdata, sign_ext: p1_sign_ext};
    else          win_req = '{we: p0_we, rtype: p0_type, addr: p0_addr,
                              wdata: p0_wdata, sign_ext: p0_sign_ext};
    accept       = (state_q == ST_IDLE) && any_valid;
    p0_req_ready = accept && !win_port;
    p1_req_ready = accept &&  win_port;
  end

  dmem_req_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check (
    .rtype_i (win_req.rtype),
    .addr_i  (win_req.addr),
    .err_o   (chk_err)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    port_d  = port_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d   = win_req;
          port_d  = win_port;
          err_d   = chk_err;
          state_d = chk_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Pointer moves to the other port on every accept, errors included.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = !win_port;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  // Memory-side and response-side outputs, all derived from registers.
  always_comb begin
    mem_write_en     = (state_q == ST_ACCESS) && req_q.we;
    mem_type_control = (state_q == ST_ACCESS) ? req_q.rtype : TYPE_WORD_IDLE;
    mem_addr         = req_q.addr;
    mem_din          = req_q.wdata;
    mem_sign_ext     = req_q.sign_ext;
    rdata_sel        = ((state_q == ST_RESP) && !err_q && !req_q.we) ? mem_dout : '0;
    p0_resp_valid    = (state_q == ST_RESP) && !port_q;
    p1_resp_valid    = (state_q == ST_RESP) &&  port_q;
    p0_resp_err      = p0_resp_valid && err_q;
    p1_resp_err      = p1_resp_valid && err_q;
    p0_resp_rdata    = port_q ? '0 : rdata_sel;
    p1_resp_rdata    = port_q ? rdata_sel : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [31:0] LIM = 32'h20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_we, p0_sign_ext;
  logic [1:0]  p0_type;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_sign_ext;
  logic [1:0]  p1_type;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_write_en, mem_sign_ext;
  logic [1:0]  mem_type_control;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_pulses = 0;
  int resp_pulses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
    .p0_type(p0_type), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_sign_ext(p0_sign_ext), .p0_resp_valid(p0_resp_valid),
    .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
    .p1_type(p1_type), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_sign_ext(p1_sign_ext), .p1_resp_valid(p1_resp_valid),
    .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_write_en(mem_write_en), .mem_type_control(mem_type_control),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_sign_ext(mem_sign_ext),
    .mem_dout(mem_dout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit [31:0] ext(input bit [31:0] raw, input bit [1:0] ty, input bit sx);
    case (ty)
      2'b00:   ext = sx ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
      2'b01:   ext = sx ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  endfunction

  // ---------------- datamem stand-in (environment) ----------------
  bit [7:0] dm [0:LIM-1];

  function automatic bit [7:0] dm_b(input bit [31:0] a);
    dm_b = (a < LIM) ? dm[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    bit [31:0] a;
    a = mem_addr;
    if (mem_write_en && a + 32'd3 < LIM) begin
      dm[a] <= mem_din[7:0];
      if (mem_type_control != 2'b00) dm[a+1] <= mem_din[15:8];
      if (mem_type_control == 2'b10) begin
        dm[a+2] <= mem_din[23:16];
        dm[a+3] <= mem_din[31:24];
      end
    end
    mem_dout <= ext({dm_b(a+3), dm_b(a+2), dm_b(a+1), dm_b(a)},
                    mem_type_control, mem_sign_ext);
  end

  // ---------------- transaction-level reference model ----------------
  bit [7:0] ref_mem [0:LIM-1];
  int free_at = 0;            // first cycle a new request may be accepted
  int acc_at  = -1;           // cycle the memory access is presented
  int resp_at = -1;           // cycle the response pulse appears
  int last    = 1;            // port served most recently
  bit m_we, m_sx, m_err;
  bit [1:0]  m_ty;
  bit [31:0] m_addr, m_wd, m_rdata;
  int m_port;

  function automatic bit [7:0] rm_b(input bit [31:0] a);
    rm_b = (a < LIM) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit model_err(input bit [1:0] ty, input bit [31:0] a);
    longint unsigned sz;
    sz = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    model_err = (ty == 2'b11) || (ty == 2'b01 && a[0]) ||
                (ty == 2'b10 && a[1:0] != 2'b00) ||
                (longint'(a) + sz > longint'(LIM));
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1) begin
      int c, w;
      bit idle, anyv;
      bit [31:0] e_rd;
      c    = cyc;
      idle = (c >= free_at);
      anyv = p0_req_valid || p1_req_valid;
      if (p0_req_valid && p1_req_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = 1 - last;
`else
        w = 0;
`endif
      end else w = p0_req_valid ? 0 : 1;

      if (mem_write_en) we_pulses++;
      if (p0_resp_valid || p1_resp_valid) resp_pulses++;

      chk("p0_ready", p0_req_ready, idle && anyv && w == 0);
      chk("p1_ready", p1_req_ready, idle && anyv && w == 1);
      chk("mem_we",   mem_write_en, (c == acc_at) && m_we);
      chk("mem_type", mem_type_control, (c == acc_at) ? m_ty : 2'b10);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_din",  mem_din,  m_wd);
      chk("mem_sext", mem_sign_ext, m_sx);
      e_rd = (m_err || m_we) ? 32'd0 : m_rdata;
      chk("p0_rvalid", p0_resp_valid, (c == resp_at) && m_port == 0);
      chk("p1_rvalid", p1_resp_valid, (c == resp_at) && m_port == 1);
      chk("p0_rerr",   p0_resp_err,   (c == resp_at) && m_port == 0 && m_err);
      chk("p1_rerr",   p1_resp_err,   (c == resp_at) && m_port == 1 && m_err);
      chk("p0_rdata",  p0_resp_rdata, ((c == resp_at) && m_port == 0) ? e_rd : 32'd0);
      chk("p1_rdata",  p1_resp_rdata, ((c == resp_at) && m_port == 1) ? e_rd : 32'd0);

      if (c == acc_at) begin
        m_rdata = ext({rm_b(m_addr+3), rm_b(m_addr+2), rm_b(m_addr+1), rm_b(m_addr)},
                      m_ty, m_sx);
        if (m_we) begin
          ref_mem[m_addr] = m_wd[7:0];
          if (m_ty != 2'b00) ref_mem[m_addr+1] = m_wd[15:8];
          if (m_ty == 2'b10) begin
            ref_mem[m_addr+2] = m_wd[23:16];
            ref_mem[m_addr+3] = m_wd[31:24];
          end
        end
      end

      if (rst) begin
        free_at = c + 1; acc_at = -1; resp_at = -1; last = 1;
        m_we = 0; m_ty = 0; m_addr = 0; m_wd = 0; m_sx = 0; m_err = 0; m_port = 0;
      end else if (idle && anyv) begin
        m_port = w;
        last   = w;
        m_we   = w ? p1_we : p0_we;
        m_ty   = w ? p1_type : p0_type;
        m_addr = w ? p1_addr : p0_addr;
        m_wd   = w ? p1_wdata : p0_wdata;
        m_sx   = w ? p1_sign_ext : p0_sign_ext;
        m_err  = model_err(m_ty, m_addr);
        if (m_err) begin acc_at = -1; resp_at = c + 1; free_at = c + 2; end
        else       begin acc_at = c + 1; resp_at = c + 2; free_at = c + 3; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_port(input int p, input bit v, input bit we, input bit [1:0] ty,
                          input bit [31:0] a, input bit [31:0] wd, input bit sx);
    if (p == 0) begin
      p0_req_valid = v; p0_we = we; p0_type = ty; p0_addr = a; p0_wdata = wd; p0_sign_ext = sx;
    end else begin
      p1_req_valid = v; p1_we = we; p1_type = ty; p1_addr = a; p1_wdata = wd; p1_sign_ext = sx;
    end
  endtask

  task automatic txn(input int p, input bit we, input bit [1:0] ty, input bit [31:0] a,
                     input bit [31:0] wd, input bit sx,
                     output bit [31:0] rd, output bit err, output int lat);
    int t_acc;
    bit got;
    rd = 0; err = 0; lat = -1; t_acc = 0;
    @(posedge clk); #1;
    set_port(p, 1, we, ty, a, wd, sx);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? p0_req_ready : p1_req_ready) begin got = 1; t_acc = cyc; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    set_port(p, 0, 0, 0, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? p0_resp_valid : p1_resp_valid) begin
        got = 1;
        rd  = (p == 0) ? p0_resp_rdata : p1_resp_rdata;
        err = (p == 0) ? p0_resp_err   : p1_resp_err;
        lat = cyc - t_acc;
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] rd;
    bit err;
    int lat, wp0, rp0;
    int order[$];

    rst = 1;
    set_port(0, 0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_type", mem_type_control, 32'd2);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rvalid", p0_resp_valid, 32'd0);
    @(posedge clk); #1 rst = 0;

    // word store then load on port 0
    wp0 = we_pulses;
    txn(0, 1, 2'b10, 32'h10000, 32'hDEADBEEF, 0, rd, err, lat);
    chk("st_lat", lat, 2);
    chk("st_err", err, 0);
    chk("st_we_pulses", we_pulses - wp0, 1);
    txn(0, 0, 2'b10, 32'h10000, 0, 0, rd, err, lat);
    chk("ld_data", rd, 32'hDEADBEEF);
    chk("ld_lat", lat, 2);

    // misaligned half and illegal type
    wp0 = we_pulses;
    txn(0, 0, 2'b01, 32'h10001, 0, 0, rd, err, lat);
    chk("mis_err", err, 1); chk("mis_lat", lat, 1); chk("mis_rd", rd, 0);
    txn(0, 1, 2'b11, 32'h10000, 32'h55AA55AA, 0, rd, err, lat);
    chk("ill_err", err, 1); chk("ill_lat", lat, 1); chk("ill_rd", rd, 0);
    chk("err_no_we", we_pulses - wp0, 0);

    // range
    txn(0, 0, 2'b10, LIM - 4, 0, 0, rd, err, lat);
    chk("rng_ok", err, 0);
    txn(0, 0, 2'b10, LIM - 2, 0, 0, rd, err, lat);
    chk("rng_m2", err, 1);
    txn(0, 0, 2'b10, 32'hFFFFFFFC, 0, 0, rd, err, lat);
    chk("rng_wrap", err, 1);
    txn(0, 0, 2'b00, LIM - 1, 0, 0, rd, err, lat);
    chk("rng_lastbyte", err, 0);

    // sign extension
    txn(0, 1, 2'b00, 32'h10004, 32'hABCDEF80, 0, rd, err, lat);
    txn(0, 0, 2'b00, 32'h10004, 0, 1, rd, err, lat);
    chk("sx1", rd, 32'hFFFFFF80);
    txn(0, 0, 2'b00, 32'h10004, 0, 0, rd, err, lat);
    chk("sx0", rd, 32'h00000080);

    // port 1 alone, half store/load
    txn(1, 1, 2'b01, 32'h10012, 32'h0000C3A5, 0, rd, err, lat);
    chk("p1_st_lat", lat, 2);
    txn(1, 0, 2'b01, 32'h10012, 0, 1, rd, err, lat);
    chk("p1_ld", rd, 32'hFFFFC3A5);

    // both ports continuously valid
    @(posedge clk); #1;
    set_port(0, 1, 0, 2'b10, 32'h10000, 0, 0);
    set_port(1, 1, 0, 2'b10, 32'h10010, 0, 0);
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      @(negedge clk);
      if (p0_req_ready) order.push_back(0);
      if (p1_req_ready) order.push_back(1);
    end
    @(posedge clk); #1;
    set_port(0, 0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0, 0);
    chk("grant_count", order.size(), 6);
    for (int k = 0; k < order.size() && k < 6; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("grant_%0d", k), order[k], k % 2);
`else
      chk($sformatf("grant_%0d", k), order[k], 0);
`endif
    end
    repeat (4) @(posedge clk);

    // reset during ACCESS of a store
    #1 set_port(0, 1, 1, 2'b10, 32'h10008, 32'h12345678, 0);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (p0_req_ready) got = 1;
      end
      if (!got) chk("rstacc_accept", 0, 1);
    end
    @(posedge clk); #1;
    set_port(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    rp0 = resp_pulses;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_type", mem_type_control, 32'd2);
    chk("post_rst_addr", mem_addr, 32'd0);
    chk("post_rst_din",  mem_din, 32'd0);
    chk("post_rst_we",   mem_write_en, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_resp", resp_pulses - rp0, 0);
    txn(0, 0, 2'b10, 32'h10008, 0, 0, rd, err, lat);
    chk("rst_store_kept", rd, 32'h12345678);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
